fc_cmd_arbiter: RTL and testbench

Shares the single flash-controller command port between NREQ requesters, such as a host port and a background copy engine. Each requester submits a 33-bit flash/memory transfer command. The block arbitrates round-robin, issues the winning command to the flash controller, and holds it stable until the controller signals completion. It then returns a completion pulse to the owner, and it recovers a hung controller with a timeout and a local reset.

---
 rtl/fc_cmd_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_fc_cmd_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_cmd_arbiter.sv
// fc_cmd_arbiter: round-robin sharing of one flash-controller command port
// among NREQ requesters. It returns completion to the owner and recovers a
// hung controller with a timeout and a local fc_rst.
//
// Ports
//   clk, rst        : clock; asynchronous active-high reset
//   req, req_cmd    : per-requester request level and flattened commands
//   gnt, cpl, err   : one-hot grant and completion pulses; err marks an abort
//   busy            : a command is owned, from grant through completion/abort
//   fc_cmd/fc_start : registered command and 1-cycle start strobe to controller
//   fc_done         : controller ready (after its reset) / command complete
//   fc_rst          : active-high reset to the controller on abort
module fc_cmd_arbiter #(
  parameter int NREQ    = 4,
  parameter int CW      = 33,
  parameter int TIMEOUT = 4095,
  parameter int RST_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] req_cmd,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    cpl,
  output logic               err,
  output logic               busy,
  output logic [CW-1:0]      fc_cmd,
  output logic               fc_start,
  input  logic               fc_done,
  output logic               fc_rst
);

  localparam int PW   = $clog2(NREQ);
  localparam int TMAX = (TIMEOUT > RST_CYC) ? TIMEOUT : RST_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] TMO   = TW'(TIMEOUT);
  localparam logic [TW-1:0] RLAST = TW'(RST_CYC - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ABORT
  } state_t;

  state_t state, state_d;

  logic [PW-1:0]   ptr, ptr_d;
  logic [PW-1:0]   owner, owner_d;
  logic            own_vld, own_vld_d;
  logic [TW-1:0]   timer, timer_d;

  logic [PW-1:0]   win, idx;
  logic            hit;
  logic [NREQ-1:0] win_oh, own_oh;
  logic [CW-1:0]   win_cmd;

  logic [NREQ-1:0] gnt_d, cpl_d;
  logic            err_d, busy_d;
  logic            fc_start_d, fc_rst_d;
  logic [CW-1:0]   fc_cmd_d;

  // First set request at or above the pointer, wrapping.
  always_comb begin
    win = ptr;
    idx = ptr;
    hit = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!hit && req[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
  end

  always_comb begin
    win_oh  = '0;
    own_oh  = '0;
    win_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_oh[i] = (win == PW'(i));
      own_oh[i] = (owner == PW'(i));
      if (win == PW'(i)) begin
        win_cmd = req_cmd[i*CW +: CW];
      end
    end
  end

  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    owner_d    = owner;
    own_vld_d  = own_vld;
    timer_d    = timer;
    gnt_d      = '0;
    cpl_d      = '0;
    err_d      = 1'b0;
    busy_d     = busy;
    fc_cmd_d   = fc_cmd;
    fc_start_d = 1'b0;
    fc_rst_d   = 1'b0;

    unique case (state)
      S_INIT: begin
        if (fc_done) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if (timer == TMO) begin
          // controller never came up: reset it, nobody to notify
          state_d   = S_ABORT;
          timer_d   = '0;
          fc_rst_d  = 1'b1;
          own_vld_d = 1'b0;
        end else begin
          timer_d = timer + 1'b1;
        end
      end

      S_IDLE: begin
        if (hit) begin
          gnt_d     = win_oh;
          fc_cmd_d  = win_cmd;
          owner_d   = win;
          own_vld_d = 1'b1;
          ptr_d     = PW'((int'(win) + 1) % NREQ);
          busy_d    = 1'b1;
          timer_d   = '0;
          state_d   = S_ISSUE;
        end
      end

      S_ISSUE: begin
        fc_start_d = 1'b1;
        timer_d    = '0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        // completion takes priority over a coincident expiry
        if (fc_done) begin
          cpl_d     = own_oh;
          busy_d    = 1'b0;
          own_vld_d = 1'b0;
          state_d   = S_IDLE;
        end else if (timer == TMO) begin
          state_d  = S_ABORT;
          timer_d  = '0;
          fc_rst_d = 1'b1;
        end else begin
          timer_d = timer + 1'b1;
        end
      end

      S_ABORT: begin
        if (timer == RLAST) begin
          if (own_vld) begin
            cpl_d = own_oh;
            err_d = 1'b1;
          end
          own_vld_d = 1'b0;
          busy_d    = 1'b0;
          timer_d   = '0;
          state_d   = S_INIT;
        end else begin
          fc_rst_d = 1'b1;
          timer_d  = timer + 1'b1;
        end
      end

      default: begin
        state_d = S_INIT;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_INIT;
      ptr      <= '0;
      owner    <= '0;
      own_vld  <= 1'b0;
      timer    <= '0;
      gnt      <= '0;
      cpl      <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      fc_cmd   <= '0;
      fc_start <= 1'b0;
      fc_rst   <= 1'b0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      owner    <= owner_d;
      own_vld  <= own_vld_d;
      timer    <= timer_d;
      gnt      <= gnt_d;
      cpl      <= cpl_d;
      err      <= err_d;
      busy     <= busy_d;
      fc_cmd   <= fc_cmd_d;
      fc_start <= fc_start_d;
      fc_rst   <= fc_rst_d;
    end
  end

endmodule

// File: tb/tb_fc_cmd_arbiter.sv
// tb_fc_cmd_arbiter: randomized scoreboard bench for fc_cmd_arbiter.
// Driver queues expected grants/completions; a monitor checks them.
module tb_fc_cmd_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 33;
  localparam int TMO  = 16;
  localparam int RCYC = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*CW-1:0] req_cmd = '0;
  logic [NREQ-1:0]    gnt, cpl;
  logic               err, busy, fc_start, fc_rst;
  logic [CW-1:0]      fc_cmd;
  logic               fc_done;

  fc_cmd_arbiter #(
    .NREQ(NREQ), .CW(CW), .TIMEOUT(TMO), .RST_CYC(RCYC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd),
    .gnt(gnt), .cpl(cpl), .err(err), .busy(busy),
    .fc_cmd(fc_cmd), .fc_start(fc_start),
    .fc_done(fc_done), .fc_rst(fc_rst)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [CW-1:0] cmd; } gexp_t;
  typedef struct { int idx; bit err; } cexp_t;

  gexp_t gq[$];
  cexp_t cq[$];

  int errors = 0;
  int checks = 0;
  int mptr = 0;
  int aborts_exp = 0;
  int rst_events = 0;
  int done_dly = -1;
  logic [CW-1:0] cmdv [NREQ];

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic rand_cmds();
    for (int i = 0; i < NREQ; i++)
      cmdv[i] = CW'({$urandom(), $urandom()});
  endtask

  task automatic drive_cmds();
    for (int i = 0; i < NREQ; i++)
      req_cmd[i*CW +: CW] = cmdv[i];
  endtask

  // one command: predict winner from the round-robin rule, queue
  // expectations, raise req until granted, then wait for completion
  task automatic txn(input logic [NREQ-1:0] pat, input int dly,
                     input bit want_cpl);
    int w = -1;
    int n;
    gexp_t g;
    cexp_t c;
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && pat[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
    mptr = (w + 1) % NREQ;
    g.idx = w;
    g.cmd = cmdv[w];
    gq.push_back(g);
    if (want_cpl) begin
      c.idx = w;
      c.err = (dly < 1 || dly > TMO);
      if (c.err) aborts_exp++;
      cq.push_back(c);
    end
    done_dly = dly;
    drive_cmds();
    req = pat;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (gnt == '0 && n < 80);
    req = '0;
    checks++;
    if (gnt == '0) begin
      errors++;
      $display("FAIL gnt_wait: got none want gnt[%0d]", w);
    end
    if (want_cpl) begin
      n = 0;
      do begin
        @(posedge clk); #1; n++;
      end while (cpl == '0 && n < 80);
      checks++;
      if (cpl == '0) begin
        errors++;
        $display("FAIL cpl_wait: got none want cpl[%0d]", w);
      end
    end
  endtask

  // controller model: ready 3 cycles after any reset, done after done_dly
  initial begin
    int cnt = -1;
    logic pr = 1'b1;
    logic prst = 1'b0;
    fc_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      fc_done = 1'b0;
      if (rst) begin
        cnt = -1;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            fc_done = 1'b1;
            cnt = -1;
          end
        end
        if (pr) cnt = 3;
        if (prst && !fc_rst) cnt = 3;
        if (fc_start && done_dly > 0) cnt = done_dly;
      end
      pr = rst;
      prst = fc_rst;
    end
  end

  // monitor
  initial begin
    logic [NREQ-1:0] pg = '0;
    logic [NREQ-1:0] oh;
    int rc = 0;
    gexp_t g;
    cexp_t c;
    forever begin
      @(negedge clk);
      if (rst) begin
        pg = '0;
        rc = 0;
      end else begin
        if (gnt != '0) begin
          if (gq.size() == 0) begin
            checks++; errors++;
            $display("FAIL gnt_unexpected: got %b want none", gnt);
          end else begin
            g = gq.pop_front();
            oh = '0;
            oh[g.idx] = 1'b1;
            chk("gnt", 64'(gnt), 64'(oh));
            chk("fc_cmd", 64'(fc_cmd), 64'(g.cmd));
            chk("busy_at_gnt", 64'(busy), 64'(1));
          end
        end
        if (cpl != '0) begin
          if (cq.size() == 0) begin
            checks++; errors++;
            $display("FAIL cpl_unexpected: got %b want none", cpl);
          end else begin
            c = cq.pop_front();
            oh = '0;
            oh[c.idx] = 1'b1;
            chk("cpl", 64'(cpl), 64'(oh));
            chk("err", 64'(err), 64'(c.err));
            chk("busy_at_cpl", 64'(busy), 64'(0));
          end
        end else if (err) begin
          chk("err_without_cpl", 64'(err), 64'(0));
        end
        if (fc_start || pg != '0)
          chk("fc_start_after_gnt", 64'(fc_start), 64'(pg != '0));
        if (fc_rst) begin
          rc++;
        end else if (rc > 0) begin
          chk("fc_rst_len", 64'(rc), 64'(RCYC));
          rst_events++;
          rc = 0;
        end
        pg = gnt;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] pat;
    int r, dly, n, seen;
    gexp_t g;
    cexp_t c;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_cpl", 64'(cpl), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_fc_cmd", 64'(fc_cmd), 64'(0));
    chk("rst_fc_rst", 64'(fc_rst), 64'(0));
    rst = 1'b0;

    // idle after controller ready, no requests
    repeat (10) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'(0));

    // all requesting: grants rotate 0,1,2,3,0
    rand_cmds();
    drive_cmds();
    for (int j = 0; j < 5; j++) begin
      g.idx = mptr;
      g.cmd = cmdv[mptr];
      gq.push_back(g);
      c.idx = mptr;
      c.err = 1'b0;
      cq.push_back(c);
      mptr = (mptr + 1) % NREQ;
    end
    done_dly = 5;
    req = '1;
    n = 0;
    seen = 0;
    while (seen < 5 && n < 300) begin
      @(posedge clk); #1; n++;
      if (gnt != '0) seen++;
    end
    req = '0;
    chk("rr_grant_count", 64'(seen), 64'(5));
    repeat (20) @(posedge clk);
    #1;

    // single requester 1 with fixed command
    rand_cmds();
    cmdv[1] = 33'h1_0000_00AB;
    txn(4'b0010, 12, 1'b1);

    // done exactly at timeout boundary
    rand_cmds();
    txn(4'b0001, TMO, 1'b1);

    // timeout abort for requester 2
    rand_cmds();
    txn(4'b0100, -1, 1'b1);

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      rand_cmds();
      pat = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      r = $urandom_range(0, 9);
      if (r == 0) dly = -1;
      else if (r == 1) dly = TMO;
      else dly = $urandom_range(1, TMO + 1);
      txn(pat, dly, 1'b1);
    end

    // async reset while requester 3 waits on the controller
    rand_cmds();
    txn(4'b1000, -1, 1'b0);
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_gnt", 64'(gnt), 64'(0));
    chk("arst_cpl", 64'(cpl), 64'(0));
    chk("arst_err", 64'(err), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_fc_cmd", 64'(fc_cmd), 64'(0));
    chk("arst_fc_start", 64'(fc_start), 64'(0));
    chk("arst_fc_rst", 64'(fc_rst), 64'(0));
    mptr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rand_cmds();
    txn('1, 4, 1'b1);

    repeat (30) @(posedge clk);
    chk("gnt_queue_empty", 64'(gq.size()), 64'(0));
    chk("cpl_queue_empty", 64'(cq.size()), 64'(0));
    chk("abort_count", 64'(rst_events), 64'(aborts_exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
